conv_row_sequencer: RTL and testbench
=====================================

// Module: conv_row_sequencer
// PURPOSE
//  Parametrised convolution control sequencer. For each kernel it walks channels x output rows,
//  requests and accepts one input strip of PIC_SIZE pixels per row, then waits ROW_WAIT compute cycles.
//  It then streams OUT_SIZE*OUT_SIZE results to the feature-map writer over a valid/ready handshake.
//  Sits between the picture buffer (upstream) and the result RAM writer (downstream).
// PARAMETERS
//  WIDTH          8   pixel/result data width
//  KERNEL_SIZE    5   square kernel edge; OUT_SIZE = PIC_SIZE-KERNEL_SIZE+1
//  PIC_SIZE      28   square input edge; pixels per fetched strip
//  CHANNEL        3   input channels per kernel
//  KERNEL_NUMBER  1   kernels processed per conv_start
//  ROW_WAIT      68   compute cycles per row after strip fetch (>=1)
// PORTS
//  clk                 in   1      clock
//  rst_n               in   1      asynchronous, active-low reset
//  conv_start          in   1      start request, sampled in IDLE only
//  pic                 in   WIDTH  input pixel
//  pic_valid           in   1      pixel qualifier, counted only in FETCH
//  need_pic            out  1      1-cycle pulse: upstream must send next strip
//  busy                out  1      high in every state except IDLE
//  out_ready           in   1      downstream accepts result
//  conv_result_valid   out  1      result valid (WRITE state)
//  conv_result         out  WIDTH  result data
//  conv_result_addr    out  AW     AW=$clog2(OUT_SIZE*OUT_SIZE); output pixel index
//  conv_result_kernel  out  KW     KW=max(1,$clog2(KERNEL_NUMBER)); kernel of current result
//  conv_finish         out  1      1-cycle pulse: all kernels written
// BEHAVIOUR
//  Reset: state IDLE; all outputs and counters 0; checksum 0.
//  FSM IDLE->FETCH->COMPUTE->(FETCH|WRITE)->(FETCH|DONE)->IDLE.
//  IDLE: conv_start=1 -> FETCH; row, channel, kernel, checksum cleared. Start while busy is ignored.
//  FETCH: need_pic=1 on the first cycle in FETCH only.
//   - Each pic_valid adds pic to the checksum (mod 2^WIDTH) and increments pix_cnt.
//   - Beat PIC_SIZE-1 -> COMPUTE next cycle. pix_cnt is then cleared.
//  COMPUTE: wait_cnt counts 0..ROW_WAIT-1; at ROW_WAIT-1 the row advances.
//   - Row order: row fastest, then channel.
//   - Row not last of the kernel (row==OUT_SIZE-1 && ch==CHANNEL-1 is last) -> FETCH.
//   - Last row -> WRITE with addr 0.
//  WRITE: conv_result_valid=1. conv_result = checksum + addr[WIDTH-1:0] (truncating).
//   - Data, addr and kernel are held stable while out_ready=0.
//   - Handshake (valid&ready): addr+1. On addr==OUT_SIZE^2-1:
//     - Not the last kernel: kernel+1, checksum cleared, row/channel cleared -> FETCH.
//     - Last kernel -> DONE.
//  DONE: conv_finish=1 for exactly one cycle -> IDLE. conv_start in DONE is ignored.
//  pic_valid outside FETCH is ignored. Checksum is never modified outside FETCH.
//  Per-row latency (pic_valid every cycle): 1+PIC_SIZE+ROW_WAIT-1 ... exactly PIC_SIZE+ROW_WAIT cycles FETCH-entry to next FETCH-entry.
//  All counters wrap only by explicit clear; no modulo overflow is permitted.
//  Reset asserted mid-operation -> immediate IDLE; no conv_finish is emitted.
// CONFIGURATION
//  CONV_SEQ_ABORT_EN defined: adds input conv_abort (1 bit).
//   - conv_abort=1 in any non-IDLE state -> IDLE next cycle.
//   - Counters and checksum are cleared. need_pic/valid/finish are low from that cycle.
//   - Abort takes priority over a simultaneous handshake or finish.
//  Undefined: no conv_abort port; only reset stops a run.
// STRUCTURE
//  Package conv_pkg holds:
//   - typedef enum logic[2:0] conv_seq_state_t {IDLE,FETCH,COMPUTE,WRITE,DONE}.
//   - function out_size(pic,kernel), used by this block and the writer.
//  Sub-module conv_result_streamer holds the WRITE-phase addr counter and valid/ready logic.
//   - Inputs: start, checksum. Outputs: last-beat pulse.
// TESTING (PIC_SIZE=6,KERNEL_SIZE=3,CHANNEL=2,KERNEL_NUMBER=2,ROW_WAIT=4,WIDTH=8: OUT_SIZE=4, 8 rows/kernel)
//  1. Reset -> all outputs 0, busy=0. Start, pic_valid always 1, pic=1, out_ready=1:
//     - 8 need_pic pulses 10 cycles apart.
//     - Then 16 results, addr 0..15, data 48+addr, kernel 0.
//     - Then kernel 1 identical.
//     - conv_finish is a single pulse.
//  2. Backpressure: out_ready toggles 1/0 each cycle -> data, addr and kernel are held while ready=0.
//     - No result is lost or duplicated (16 unique addrs per kernel).
//  3. pic_valid gaps (every 3rd cycle) -> FETCH lasts 16 cycles per strip.
//     - need_pic still pulses once per row; the checksum is unchanged vs test 1.
//  4. pic=200 on all beats -> checksum 48*200 mod 256 = 128.
//     - First result data=128; data at addr 15 = 143 (truncation check).
//  5. conv_start pulsed during COMPUTE and in DONE -> ignored. Reset mid-WRITE -> IDLE, no finish.
//     - A new start then completes normally.
//  6. CONV_SEQ_ABORT_EN: abort during FETCH of row 3 -> next cycle busy=0, need_pic=0.
//     - A restart yields results identical to test 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution control path.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COMPUTE,
    WRITE,
    DONE
  } conv_seq_state_t;

  function automatic int out_size(int pic, int kernel);
    return pic - kernel + 1;
  endfunction

  function automatic int clog2_min1(int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/conv_result_streamer.sv
// WRITE-phase result streamer: address counter and valid/ready handshake.
// Holds data/addr stable under backpressure; pulses last on the final accepted beat.
module conv_result_streamer
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NPIX  = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] checksum,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    addr,
  output logic             last
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          hs;

  assign hs    = valid_q & out_ready & ~clear;
  assign last  = hs && (addr_q == AW'(NPIX - 1));
  assign valid = valid_q & ~clear;
  assign addr  = addr_q;
  assign data  = checksum + WIDTH'(addr_q);

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clear) begin
      valid_d = 1'b0;
      addr_d  = '0;
    end else if (start) begin
      valid_d = 1'b1;
      addr_d  = '0;
    end else if (last) begin
      valid_d = 1'b0;
      addr_d  = '0;
    end else if (hs) begin
      addr_d  = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/conv_row_sequencer.sv
// Convolution row sequencer: fetch strips, wait compute, stream results per kernel.
// Optional CONV_SEQ_ABORT_EN adds a conv_abort input that returns any run to IDLE.
module conv_row_sequencer
  import conv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int KERNEL_SIZE   = 5,
  parameter int PIC_SIZE      = 28,
  parameter int CHANNEL       = 3,
  parameter int KERNEL_NUMBER = 1,
  parameter int ROW_WAIT      = 68,
  localparam int OUT_SIZE     = out_size(PIC_SIZE, KERNEL_SIZE),
  localparam int NPIX         = OUT_SIZE * OUT_SIZE,
  localparam int AW           = clog2_min1(NPIX),
  localparam int KW           = clog2_min1(KERNEL_NUMBER)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conv_start,
`ifdef CONV_SEQ_ABORT_EN
  input  logic             conv_abort,
`endif
  input  logic [WIDTH-1:0] pic,
  input  logic             pic_valid,
  output logic             need_pic,
  output logic             busy,
  input  logic             out_ready,
  output logic             conv_result_valid,
  output logic [WIDTH-1:0] conv_result,
  output logic [AW-1:0]    conv_result_addr,
  output logic [KW-1:0]    conv_result_kernel,
  output logic             conv_finish
);

  localparam int PW = clog2_min1(PIC_SIZE);
  localparam int WW = clog2_min1(ROW_WAIT);
  localparam int RW = clog2_min1(OUT_SIZE);
  localparam int CW = clog2_min1(CHANNEL);

  conv_seq_state_t  state_q, state_d;
  logic             first_q, first_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [KW-1:0]    kern_q, kern_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             wr_start, wr_last, abort_hit, last_row;

`ifdef CONV_SEQ_ABORT_EN
  assign abort_hit = conv_abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_row = (row_q == RW'(OUT_SIZE - 1)) &&
                    (ch_q == CW'(CHANNEL - 1));

  always_comb begin
    state_d  = state_q;
    first_d  = 1'b0;
    pix_d    = pix_q;
    wait_d   = wait_q;
    row_d    = row_q;
    ch_d     = ch_q;
    kern_d   = kern_q;
    sum_d    = sum_q;
    wr_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (conv_start) begin
          state_d = FETCH;
          first_d = 1'b1;
          pix_d   = '0;
          wait_d  = '0;
          row_d   = '0;
          ch_d    = '0;
          kern_d  = '0;
          sum_d   = '0;
        end
      end
      FETCH: begin
        if (pic_valid) begin
          sum_d = sum_q + pic;
          if (pix_q == PW'(PIC_SIZE - 1)) begin
            pix_d   = '0;
            state_d = COMPUTE;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (wait_q == WW'(ROW_WAIT - 1)) begin
          wait_d = '0;
          if (last_row) begin
            state_d  = WRITE;
            wr_start = 1'b1;
          end else begin
            state_d = FETCH;
            first_d = 1'b1;
            if (row_q == RW'(OUT_SIZE - 1)) begin
              row_d = '0;
              ch_d  = ch_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WRITE: begin
        if (wr_last) begin
          if (kern_q == KW'(KERNEL_NUMBER - 1)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            first_d = 1'b1;
            kern_d  = kern_q + 1'b1;
            sum_d   = '0;
            row_d   = '0;
            ch_d    = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the state logic decided this cycle
    if (abort_hit) begin
      state_d = IDLE;
      first_d = 1'b0;
      pix_d   = '0;
      wait_d  = '0;
      row_d   = '0;
      ch_d    = '0;
      kern_d  = '0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      pix_q   <= '0;
      wait_q  <= '0;
      row_q   <= '0;
      ch_q    <= '0;
      kern_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      pix_q   <= pix_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      kern_q  <= kern_d;
      sum_q   <= sum_d;
    end
  end

  conv_result_streamer #(
    .WIDTH (WIDTH),
    .NPIX  (NPIX),
    .AW    (AW)
  ) u_stream (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wr_start),
    .clear     (abort_hit),
    .checksum  (sum_q),
    .out_ready (out_ready),
    .valid     (conv_result_valid),
    .data      (conv_result),
    .addr      (conv_result_addr),
    .last      (wr_last)
  );

  assign busy               = (state_q != IDLE);
  assign need_pic           = (state_q == FETCH) && first_q && !abort_hit;
  assign conv_finish        = (state_q == DONE) && !abort_hit;
  assign conv_result_kernel = kern_q;

endmodule

// File: tb/tb_conv_row_sequencer.sv
// Directed self-checking bench for conv_row_sequencer (small config, OUT_SIZE=4).
// Define CONV_SEQ_ABORT_EN to include the abort scenario.
module tb_conv_row_sequencer;

  logic       clk;
  logic       rst_n;
  logic       conv_start;
`ifdef CONV_SEQ_ABORT_EN
  logic       conv_abort;
`endif
  logic [7:0] pic;
  logic       pic_valid;
  logic       need_pic;
  logic       busy;
  logic       out_ready;
  logic       conv_result_valid;
  logic [7:0] conv_result;
  logic [3:0] conv_result_addr;
  logic [0:0] conv_result_kernel;
  logic       conv_finish;

  int checks;
  int errors;

  logic [7:0] res_data [64];
  logic [3:0] res_addr [64];
  logic [0:0] res_kern [64];
  int         np_cyc   [64];
  int n_res, n_np, n_fin, hold_viol;
  bit busy_after, timed_out;

  conv_row_sequencer #(
    .WIDTH         (8),
    .KERNEL_SIZE   (3),
    .PIC_SIZE      (6),
    .CHANNEL       (2),
    .KERNEL_NUMBER (2),
    .ROW_WAIT      (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .conv_start         (conv_start),
`ifdef CONV_SEQ_ABORT_EN
    .conv_abort         (conv_abort),
`endif
    .pic                (pic),
    .pic_valid          (pic_valid),
    .need_pic           (need_pic),
    .busy               (busy),
    .out_ready          (out_ready),
    .conv_result_valid  (conv_result_valid),
    .conv_result        (conv_result),
    .conv_result_addr   (conv_result_addr),
    .conv_result_kernel (conv_result_kernel),
    .conv_finish        (conv_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] exp_word(int i, int sum);
    logic [7:0] d;
    d = 8'(sum + (i % 16));
    return {1'(i / 16), 4'(i % 16), d};
  endfunction

  // Drives one full run from IDLE and records what the DUT produced.
  task automatic run_conv(input logic [7:0] pv, input bit gap,
                          input bit bp, input bit spam);
    int phase, post;
    bit fin_seen, pv_, pr_;
    logic [7:0] pd;
    logic [3:0] pa;
    logic [0:0] pk;
    n_res = 0; n_np = 0; n_fin = 0; hold_viol = 0;
    busy_after = 0; timed_out = 0;
    phase = 0; post = 0; fin_seen = 0; pv_ = 0; pr_ = 0;
    pd = '0; pa = '0; pk = '0;
    @(negedge clk);
    pic = pv;
    pic_valid = 1'b0;
    out_ready = 1'b1;
    conv_start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (pv_ && !pr_ && (!conv_result_valid || conv_result !== pd ||
          conv_result_addr !== pa || conv_result_kernel !== pk))
        hold_viol++;
      if (need_pic) begin
        if (n_np < 64) np_cyc[n_np] = cyc;
        n_np++;
        phase = 0;
      end
      if (conv_finish) begin
        n_fin++;
        fin_seen = 1;
      end else if (fin_seen) begin
        post++;
        if (busy) busy_after = 1;
      end
      conv_start = spam ? busy : 1'b0;
      pic_valid = gap ? (phase % 3 == 0) : 1'b1;
      phase++;
      out_ready = bp ? (cyc % 2 == 1) : 1'b1;
      if (conv_result_valid && out_ready) begin
        if (n_res < 64) begin
          res_data[n_res] = conv_result;
          res_addr[n_res] = conv_result_addr;
          res_kern[n_res] = conv_result_kernel;
        end
        n_res++;
      end
      pv_ = conv_result_valid;
      pr_ = out_ready;
      pd = conv_result;
      pa = conv_result_addr;
      pk = conv_result_kernel;
      if (post == 3) break;
    end
    if (post < 3) timed_out = 1;
    conv_start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    conv_start = 1'b0;
    pic = '0;
    pic_valid = 1'b0;
    out_ready = 1'b0;
`ifdef CONV_SEQ_ABORT_EN
    conv_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %0b want 0", busy);
    end
    checks++;
    if (need_pic !== 1'b0) begin
      errors++; $display("FAIL reset_need_pic got %0b want 0", need_pic);
    end
    checks++;
    if (conv_result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b want 0", conv_result_valid);
    end
    checks++;
    if ({conv_result, conv_result_addr, conv_result_kernel} !== 13'd0) begin
      errors++;
      $display("FAIL reset_data got %0h/%0h/%0h want 0", conv_result,
               conv_result_addr, conv_result_kernel);
    end
    checks++;
    if (conv_finish !== 1'b0) begin
      errors++; $display("FAIL reset_finish got %0b want 0", conv_finish);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy got %0b want 0", busy);
    end
  endtask

  task automatic test_basic;
    run_conv(8'd1, 0, 0, 0);
    checks++;
    if (timed_out || n_fin !== 1) begin
      errors++; $display("FAIL t1_finish got %0d timeout %0b want 1", n_fin, timed_out);
    end
    checks++;
    if (n_np !== 16) begin
      errors++; $display("FAIL t1_need_pic_cnt got %0d want 16", n_np);
    end
    for (int i = 1; i < 8 && i < n_np; i++) begin
      checks++;
      if (np_cyc[i] - np_cyc[i-1] !== 10) begin
        errors++;
        $display("FAIL t1_row_gap %0d got %0d want 10", i, np_cyc[i] - np_cyc[i-1]);
      end
    end
    checks++;
    if (n_np > 8 && np_cyc[8] - np_cyc[7] !== 26) begin
      errors++; $display("FAIL t1_kernel_gap got %0d want 26", np_cyc[8] - np_cyc[7]);
    end
    checks++;
    if (n_res !== 32) begin
      errors++; $display("FAIL t1_res_cnt got %0d want 32", n_res);
    end
    for (int i = 0; i < n_res && i < 32; i++) begin
      checks++;
      if ({res_kern[i], res_addr[i], res_data[i]} !== exp_word(i, 48)) begin
        errors++;
        $display("FAIL t1_result %0d got k%0d a%0d d%0d want %0h", i, res_kern[i],
                 res_addr[i], res_data[i], exp_word(i, 48));
      end
    end
    checks++;
    if (busy_after) begin
      errors++; $display("FAIL t1_idle_after got busy want idle");
    end
  endtask

  task automatic test_backpressure;
    run_conv(8'd1, 0, 1, 0);
    checks++;
    if (timed_out || n_fin !== 1) begin
      errors++; $display("FAIL t2_finish got %0d timeout %0b want 1", n_fin, timed_out);
    end
    checks++;
    if (hold_viol !== 0) begin
      errors++; $display("FAIL t2_hold got %0d violations want 0", hold_viol);
    end
    checks++;
    if (n_res !== 32) begin
      errors++; $display("FAIL t2_res_cnt got %0d want 32", n_res);
    end
    for (int i = 0; i < n_res && i < 32; i++) begin
      checks++;
      if ({res_kern[i], res_addr[i], res_data[i]} !== exp_word(i, 48)) begin
        errors++;
        $display("FAIL t2_result %0d got k%0d a%0d d%0d want %0h", i, res_kern[i],
                 res_addr[i], res_data[i], exp_word(i, 48));
      end
    end
  endtask

  task automatic test_pic_gaps;
    run_conv(8'd1, 1, 0, 0);
    checks++;
    if (timed_out || n_fin !== 1) begin
      errors++; $display("FAIL t3_finish got %0d timeout %0b want 1", n_fin, timed_out);
    end
    checks++;
    if (n_np !== 16) begin
      errors++; $display("FAIL t3_need_pic_cnt got %0d want 16", n_np);
    end
    checks++;
    if (n_np > 1 && np_cyc[1] - np_cyc[0] !== 20) begin
      errors++; $display("FAIL t3_row_gap got %0d want 20", np_cyc[1] - np_cyc[0]);
    end
    checks++;
    if (n_res !== 32) begin
      errors++; $display("FAIL t3_res_cnt got %0d want 32", n_res);
    end
    for (int i = 0; i < n_res && i < 32; i++) begin
      checks++;
      if ({res_kern[i], res_addr[i], res_data[i]} !== exp_word(i, 48)) begin
        errors++;
        $display("FAIL t3_result %0d got d%0d want %0h", i, res_data[i], exp_word(i, 48));
      end
    end
  endtask

  task automatic test_truncation;
    run_conv(8'd200, 0, 0, 0);
    checks++;
    if (n_res !== 32) begin
      errors++; $display("FAIL t4_res_cnt got %0d want 32", n_res);
    end
    checks++;
    if (res_data[0] !== 8'd128) begin
      errors++; $display("FAIL t4_first got %0d want 128", res_data[0]);
    end
    checks++;
    if (res_data[15] !== 8'd143) begin
      errors++; $display("FAIL t4_addr15 got %0d want 143", res_data[15]);
    end
    checks++;
    if (res_data[31] !== 8'd143 || res_kern[31] !== 1'b1) begin
      errors++;
      $display("FAIL t4_k1_last got d%0d k%0d want 143/1", res_data[31], res_kern[31]);
    end
  endtask

  task automatic test_start_reset;
    int fin, bsy, k;
    bit seen;
    run_conv(8'd1, 0, 0, 1);
    checks++;
    if (timed_out || n_fin !== 1 || busy_after) begin
      errors++;
      $display("FAIL t5_spam_finish got %0d busy_after %0b want 1/0", n_fin, busy_after);
    end
    checks++;
    if (n_res !== 32 || n_np !== 16) begin
      errors++; $display("FAIL t5_spam_cnt got %0d/%0d want 32/16", n_res, n_np);
    end
    @(negedge clk);
    conv_start = 1'b1;
    pic = 8'd1;
    pic_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    conv_start = 1'b0;
    seen = 0;
    for (k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      if (conv_result_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL t5_reach_write got timeout want valid");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, conv_result_valid, conv_finish, need_pic} !== 4'b0) begin
      errors++;
      $display("FAIL t5_reset_mid got b%0b v%0b f%0b n%0b want 0", busy,
               conv_result_valid, conv_finish, need_pic);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    fin = 0; bsy = 0;
    repeat (40) begin
      @(negedge clk);
      if (conv_finish) fin++;
      if (busy) bsy++;
    end
    checks++;
    if (fin !== 0 || bsy !== 0) begin
      errors++; $display("FAIL t5_after_reset got fin %0d busy %0d want 0/0", fin, bsy);
    end
    run_conv(8'd1, 0, 0, 0);
    checks++;
    if (n_fin !== 1 || n_res !== 32) begin
      errors++; $display("FAIL t5_restart got fin %0d res %0d want 1/32", n_fin, n_res);
    end
    for (int i = 0; i < n_res && i < 32; i++) begin
      checks++;
      if ({res_kern[i], res_addr[i], res_data[i]} !== exp_word(i, 48)) begin
        errors++;
        $display("FAIL t5_result %0d got d%0d want %0h", i, res_data[i], exp_word(i, 48));
      end
    end
  endtask

`ifdef CONV_SEQ_ABORT_EN
  task automatic test_abort;
    int np;
    bit hit;
    @(negedge clk);
    pic = 8'd1;
    pic_valid = 1'b1;
    out_ready = 1'b1;
    conv_start = 1'b1;
    np = 0; hit = 0;
    for (int k = 0; k < 500 && !hit; k++) begin
      @(negedge clk);
      conv_start = 1'b0;
      if (need_pic) np++;
      if (np == 4) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL t6_reach_row3 got %0d pulses want 4", np);
    end
    conv_abort = 1'b1;
    #1;
    checks++;
    if (need_pic !== 1'b0) begin
      errors++; $display("FAIL t6_abort_np_now got %0b want 0", need_pic);
    end
    @(negedge clk);
    conv_abort = 1'b0;
    checks++;
    if ({busy, need_pic, conv_result_valid, conv_finish} !== 4'b0) begin
      errors++;
      $display("FAIL t6_abort_idle got b%0b n%0b v%0b f%0b want 0", busy, need_pic,
               conv_result_valid, conv_finish);
    end
    run_conv(8'd1, 0, 0, 0);
    checks++;
    if (n_fin !== 1 || n_res !== 32) begin
      errors++; $display("FAIL t6_restart got fin %0d res %0d want 1/32", n_fin, n_res);
    end
    for (int i = 0; i < n_res && i < 32; i++) begin
      checks++;
      if ({res_kern[i], res_addr[i], res_data[i]} !== exp_word(i, 48)) begin
        errors++;
        $display("FAIL t6_result %0d got d%0d want %0h", i, res_data[i], exp_word(i, 48));
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_pic_gaps();
    test_truncation();
    test_start_reset();
`ifdef CONV_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
